// File: rtl/fifo_nibble_reader.sv
// Read-side controller for a 4-bit tristate-output FIFO: drains nibbles,
// packs pairs into bytes, and flushes a lone nibble after an idle timeout.
module fifo_nibble_reader #(
  parameter int RD_LAT    = 1,
  parameter int TIMEOUT   = 16,
  parameter bit MSN_FIRST = 1'b1
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       enable,
  input  logic       fifo_empty,
  input  logic [3:0] fifo_data,
  output logic       fifo_rd,
  output logic       fifo_status,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_partial,
  output logic       nib_held
);

  typedef enum logic [2:0] {IDLE, TURN, READ, WAIT, CAPT, OUT} state_t;

  // WAIT runs RD_LAT-1 cycles, counting 0 .. RD_LAT-2.
  localparam logic [1:0] WAIT_LAST = 2'(RD_LAT - 2);
  localparam logic [7:0] TO_LAST   = 8'(TIMEOUT - 1);

  state_t     state, state_d;
  logic [1:0] wait_cnt, wait_d;
  logic [7:0] to_cnt, to_d;
  logic [3:0] held_nib, held_d;
  logic [7:0] data_d;
  logic       valid_d, partial_d, nib_held_d;
  logic [7:0] full_byte, partial_byte;

  // The first nibble read lands in the upper half when MSN_FIRST is set.
  assign full_byte    = MSN_FIRST ? {held_nib, fifo_data} : {fifo_data, held_nib};
  assign partial_byte = MSN_FIRST ? {held_nib, 4'h0}      : {4'h0, held_nib};

  always_ff @(posedge clk_in or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      to_cnt      <= '0;
      held_nib    <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_partial <= 1'b0;
      nib_held    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from pre-edge values.
      state       <= state_d;
      wait_cnt    <= wait_d;
      to_cnt      <= to_d;
      held_nib    <= held_d;
      out_data    <= data_d;
      out_valid   <= valid_d;
      out_partial <= partial_d;
      nib_held    <= nib_held_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d     = state;
    wait_d      = wait_cnt;
    to_d        = to_cnt;
    held_d      = held_nib;
    data_d      = out_data;
    valid_d     = out_valid;
    partial_d   = out_partial;
    nib_held_d  = nib_held;
    fifo_rd     = 1'b0;
    fifo_status = 1'b1;

    unique case (state)
      IDLE: begin
        if (enable && !fifo_empty && !out_valid) begin
          state_d = TURN;
          to_d    = '0;
        end else if (nib_held && fifo_empty) begin
          if (to_cnt == TO_LAST) begin
            to_d       = '0;
            data_d     = partial_byte;
            valid_d    = 1'b1;
            partial_d  = 1'b1;
            nib_held_d = 1'b0;
            state_d    = OUT;
          end else begin
            to_d = to_cnt + 8'd1;
          end
        end else begin
          to_d = '0;
        end
      end

      TURN: begin
        // Bus turnaround; give up early if the FIFO drained meanwhile.
        fifo_status = 1'b0;
        state_d     = fifo_empty ? IDLE : READ;
      end

      READ: begin
        fifo_status = 1'b0;
        if (fifo_empty) begin
          state_d = IDLE;
        end else begin
          fifo_rd = 1'b1;
          wait_d  = '0;
          state_d = (RD_LAT == 1) ? CAPT : WAIT;
        end
      end

      WAIT: begin
        fifo_status = 1'b0;
        if (wait_cnt == WAIT_LAST) state_d = CAPT;
        else                       wait_d  = wait_cnt + 2'd1;
      end

      CAPT: begin
        // fifo_data is only ever looked at here.
        fifo_status = 1'b0;
        to_d        = '0;
        if (nib_held) begin
          data_d     = full_byte;
          valid_d    = 1'b1;
          partial_d  = 1'b0;
          nib_held_d = 1'b0;
          state_d    = OUT;
        end else begin
          held_d     = fifo_data;
          nib_held_d = 1'b1;
          state_d    = IDLE;
        end
      end

      OUT: begin
        if (out_ready) begin
          valid_d   = 1'b0;
          partial_d = 1'b0;
          state_d   = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule
